ddr_axi_rd_master: RTL and testbench
====================================

# ddr_axi_rd_master

AXI4 read-burst master that sits directly upstream of the DDR AXI slave port (`c0_ddr4_s_axi_ar*` / `c0_ddr4_s_axi_r*`). It accepts one linear read command (base address, length in beats), splits it into INCR bursts that never cross a 4 KB boundary, and keeps a bounded number of bursts outstanding. Returned data is forwarded as a valid/ready stream to the accelerator's weight and feature-map loaders.

## Interface
- `ADDR_WIDTH`, 32: AXI address width.
- `DATA_WIDTH`, 512: AXI data width and stream width. Beat size is `BB = DATA_WIDTH/8` bytes.
- `ID_WIDTH`, 4: AXI ID width.
- `AXI_ID`, 0: constant `arid` value.
- `MAX_BURST`, 16: maximum beats per burst, 1..256.
- `MAX_OUTSTANDING`, 4: maximum AR bursts whose `rlast` is still pending.
- `LEN_WIDTH`, 24: width of `cmd_beats`.

Ports:
- `clk` in 1: single clock, the DDR UI clock.
- `reset` in 1: synchronous, active-high.
- `init_calib_complete` in 1: the DDR is ready. No command is accepted while this is low.
- `cmd_valid` in 1, `cmd_ready` out 1: command handshake.
- `cmd_addr` in ADDR_WIDTH: byte address. The low log2(BB) bits are ignored and treated as 0.
- `cmd_beats` in LEN_WIDTH: number of beats to read. A value of 0 is legal.
- `m_axi_arid` out ID_WIDTH, `m_axi_araddr` out ADDR_WIDTH, `m_axi_arlen` out 8, `m_axi_arsize` out 3, `m_axi_arburst` out 2, `m_axi_arlock` out 1, `m_axi_arcache` out 4, `m_axi_arprot` out 3, `m_axi_arqos` out 4, `m_axi_arvalid` out 1, `m_axi_arready` in 1: AXI read-address channel.
- `m_axi_rid` in ID_WIDTH, `m_axi_rdata` in DATA_WIDTH, `m_axi_rresp` in 2, `m_axi_rlast` in 1, `m_axi_rvalid` in 1, `m_axi_rready` out 1: AXI read-data channel.
- `dout_data` out DATA_WIDTH, `dout_last` out 1, `dout_valid` out 1, `dout_ready` in 1: output stream.
- `busy` out 1: high from command accept until `done`.
- `done` out 1: one-cycle pulse when the command completes.
- `err` out 1: sticky per command. Set by any `rresp != 0`.

## Operation
- Constant AR fields:
  - `arid = AXI_ID`
  - `arsize = log2(BB)`
  - `arburst = 2'b01` (INCR)
  - `arlock = 0`, `arcache = 4'b0011`, `arprot = 0`, `arqos = 0`
- FSM states are IDLE, ISSUE and DRAIN.
- IDLE:
  - `cmd_ready = init_calib_complete`.
  - On a command handshake, latch the aligned address, set the AR beat counter `ar_rem` and the R beat counter `r_rem` to `cmd_beats`, and clear `err`.
  - If `cmd_beats == 0`, go to DRAIN. Otherwise go to ISSUE.
- ISSUE:
  - Burst length `n = min(ar_rem, MAX_BURST, (4096 - addr[11:0]) / BB)`.
  - `arlen = n-1`.
  - `arvalid` is asserted only while `outstanding < MAX_OUTSTANDING`.
  - On an AR handshake: `addr += n*BB`, `ar_rem -= n`, `outstanding++`.
  - When `ar_rem` reaches 0, go to DRAIN.
- DRAIN:
  - Wait until `r_rem == 0` and `outstanding == 0`.
  - Then pulse `done` and return to IDLE.
- `outstanding` counter:
  - Decrements on each R handshake with `rlast`.
  - On the same cycle as an AR handshake it stays unchanged.
  - It is never allowed to exceed `MAX_OUTSTANDING`.
- R path is combinational pass-through:
  - `dout_valid = rvalid & busy`
  - `rready = dout_ready & busy`
  - `dout_data = rdata`
- `dout_last = 1` on the beat where `r_rem == 1`, i.e. the last beat of the whole command, not of each burst. `r_rem` decrements on each stream handshake.
- `err` is set on any R handshake with `rresp != 0`. Data is still forwarded and the command still completes.
- `rid` is not checked because a single ID gives in-order returns.

## Timing
- Reset values:
  - `arvalid = 0`, `cmd_ready = 0` (held during the reset cycle), `busy = 0`, `done = 0`, `err = 0`.
  - `outstanding = 0`, state IDLE, `araddr = 0`, `arlen = 0`.
  - `dout_valid = 0` and `rready = 0`, because `busy = 0`.
- Command handshake in cycle N gives `arvalid = 1` and `busy = 1` in cycle N+1.
- Once asserted, `arvalid`, `araddr` and `arlen` are stable until `arready`. The next burst may be presented in the cycle after a handshake (back-to-back).
- Zero-beat command accepted in cycle N: `done` pulses in N+1. No AR is issued.
- The final stream handshake in cycle M gives `done = 1` and `busy = 0` in M+1. `cmd_ready` may be high in M+1.
- An R beat and an AR handshake in the same cycle are handled independently.
- Reset mid-operation aborts everything within 1 cycle. The DDR slave `aresetn` must be driven from the same reset, so no transactions are orphaned.

## Test plan
- **Single short command.** addr=0x1000, beats=5, slave always ready.
  - One AR: araddr=0x1000, arlen=4, arsize=6.
  - 5 stream beats; `dout_last` on beat 5 only.
  - `done` one cycle after beat 5; `err = 0`.
- **4 KB boundary split.** addr=0x0FC0, beats=40, MAX_BURST=16.
  - ARs issued in order: (0x0FC0, len 0), (0x1000, len 15), (0x1400, len 15), (0x1800, len 6).
  - 40 beats delivered in order.
- **Outstanding limit.** beats=128, `rvalid` held off for 50 cycles.
  - Exactly 4 AR handshakes, then `arvalid` stays low.
  - After the first `rlast`, the 5th AR is issued.
  - 128 beats total.
- **Backpressure.** beats=16, `dout_ready` toggling 1010….
  - `rready` mirrors `dout_ready`.
  - No beat lost or duplicated; data matches the DDR contents.
- **Error and zero-length.**
  - Slave returns rresp=2 on beat 3 of 8: all 8 beats delivered, `err = 1` until the next command accept.
  - Then beats=0: no AR, `done` in N+1, `err` cleared.
- **Reset and calibration.**
  - `init_calib_complete = 0` with `cmd_valid = 1`: `cmd_ready` stays 0.
  - `reset` asserted mid-burst (beat 7 of 32): next cycle all outputs are at reset values and `outstanding = 0`.
  - A new 4-beat command then completes normally.

Source files
------------

// File: rtl/ddr_axi_rd_master.sv
// AXI4 read-burst master: splits one linear read command into INCR bursts
// that never cross a 4 KB page, keeps a bounded number of bursts in flight
// and forwards returned beats as a valid/ready stream.
//
// state | meaning
// IDLE  | waiting for a command (only while DDR calibration is complete)
// ISSUE | presenting AR bursts until every beat of the command is requested
// DRAIN | waiting for the remaining R beats and rlast of every burst
module ddr_axi_rd_master #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 512,
    parameter int ID_WIDTH        = 4,
    parameter int AXI_ID          = 0,
    parameter int MAX_BURST       = 16,
    parameter int MAX_OUTSTANDING = 4,
    parameter int LEN_WIDTH       = 24
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  init_calib_complete,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_beats,
    output logic [ID_WIDTH-1:0]   m_axi_arid,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arlock,
    output logic [3:0]            m_axi_arcache,
    output logic [2:0]            m_axi_arprot,
    output logic [3:0]            m_axi_arqos,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [ID_WIDTH-1:0]   m_axi_rid,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready,
    output logic [DATA_WIDTH-1:0] dout_data,
    output logic                  dout_last,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int BB = DATA_WIDTH / 8;
    localparam int SZ = $clog2(BB);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] addr;
    logic [LEN_WIDTH-1:0]  ar_rem;
    logic [LEN_WIDTH-1:0]  r_rem;
    logic [OW-1:0]         outstanding;
    logic                  err_q;
    logic                  cmd_hs, ar_hs, r_hs, r_last_hs;
    logic                  drain_done;
    logic [31:0]           page_beats;
    logic [31:0]           burst_n;
    logic                  unused_bits;

    assign cmd_hs     = cmd_valid & cmd_ready;
    assign ar_hs      = m_axi_arvalid & m_axi_arready;
    assign r_hs       = m_axi_rvalid & m_axi_rready;
    assign r_last_hs  = r_hs & m_axi_rlast;
    assign drain_done = (state == DRAIN) && (r_rem == '0) && (outstanding == '0);

    // rid is ignored: a single ID returns in order
    assign unused_bits = ^{m_axi_rid, cmd_addr[SZ-1:0]};

    // next burst length: limited by remaining beats, MAX_BURST and the 4 KB page
    always_comb begin
        page_beats = (32'd4096 - 32'(addr[11:0])) >> SZ;
        burst_n    = 32'(ar_rem);
        if (burst_n > 32'(MAX_BURST)) begin
            burst_n = 32'(MAX_BURST);
        end
        if (burst_n > page_beats) begin
            burst_n = page_beats;
        end
    end

    // AR channel: constant fields plus the current burst
    assign m_axi_arid    = ID_WIDTH'(AXI_ID);
    assign m_axi_araddr  = addr;
    assign m_axi_arlen   = (state == ISSUE) ? 8'(burst_n - 32'd1) : 8'd0;
    assign m_axi_arsize  = 3'(SZ);
    assign m_axi_arburst = 2'b01;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arcache = 4'b0011;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_arqos   = 4'b0000;
    assign m_axi_arvalid = (state == ISSUE) && (outstanding < OW'(MAX_OUTSTANDING));

    // command/status; busy already drops in the cycle done pulses
    assign cmd_ready = (state == IDLE) && init_calib_complete && !reset;
    assign busy      = (state == ISSUE) || ((state == DRAIN) && !drain_done);
    assign done      = drain_done;
    assign err       = err_q;

    // R channel passes straight through to the stream while a command is live
    assign dout_valid   = m_axi_rvalid & busy;
    assign m_axi_rready = dout_ready & busy;
    assign dout_data    = m_axi_rdata;
    assign dout_last    = busy && (r_rem == LEN_WIDTH'(1));

    // state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (cmd_hs) begin
                    state_nxt = (cmd_beats == '0) ? DRAIN : ISSUE;
                end
            end
            ISSUE: begin
                if (ar_hs && (ar_rem == LEN_WIDTH'(burst_n))) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_done) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // address, beat counters and sticky error
    always_ff @(posedge clk) begin
        if (reset) begin
            addr   <= '0;
            ar_rem <= '0;
            r_rem  <= '0;
            err_q  <= 1'b0;
        end else if (cmd_hs) begin
            addr   <= {cmd_addr[ADDR_WIDTH-1:SZ], {SZ{1'b0}}};
            ar_rem <= cmd_beats;
            r_rem  <= cmd_beats;
            err_q  <= 1'b0;
        end else begin
            if (ar_hs) begin
                addr   <= addr + ADDR_WIDTH'(burst_n << SZ);
                ar_rem <= ar_rem - LEN_WIDTH'(burst_n);
            end
            if (r_hs) begin
                r_rem <= r_rem - LEN_WIDTH'(1);
                if (m_axi_rresp != 2'b00) begin
                    err_q <= 1'b1;
                end
            end
        end
    end

    // bursts in flight: +1 per AR, -1 per rlast, unchanged when both coincide
    always_ff @(posedge clk) begin
        if (reset) begin
            outstanding <= '0;
        end else begin
            case ({ar_hs, r_last_hs})
                2'b10:   outstanding <= outstanding + OW'(1);
                2'b01:   outstanding <= outstanding - OW'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

endmodule

// File: tb/tb_ddr_axi_rd_master.sv
// Bench for ddr_axi_rd_master: a DDR slave model with in-order bursts and
// a scoreboard of expected AR bursts and stream beats.
module tb_ddr_axi_rd_master;

    localparam int AW = 32;
    localparam int DW = 512;
    localparam int IW = 4;
    localparam int LW = 24;

    logic          clk = 1'b0;
    logic          reset;
    logic          init_calib_complete;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr;
    logic [LW-1:0] cmd_beats;
    logic [IW-1:0] m_axi_arid;
    logic [AW-1:0] m_axi_araddr;
    logic [7:0]    m_axi_arlen;
    logic [2:0]    m_axi_arsize;
    logic [1:0]    m_axi_arburst;
    logic          m_axi_arlock;
    logic [3:0]    m_axi_arcache;
    logic [2:0]    m_axi_arprot;
    logic [3:0]    m_axi_arqos;
    logic          m_axi_arvalid;
    logic          m_axi_arready;
    logic [IW-1:0] m_axi_rid;
    logic [DW-1:0] m_axi_rdata;
    logic [1:0]    m_axi_rresp;
    logic          m_axi_rlast;
    logic          m_axi_rvalid;
    logic          m_axi_rready;
    logic [DW-1:0] dout_data;
    logic          dout_last;
    logic          dout_valid;
    logic          dout_ready;
    logic          busy;
    logic          done;
    logic          err;

    ddr_axi_rd_master u_dut (
        .clk(clk), .reset(reset), .init_calib_complete(init_calib_complete),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_beats(cmd_beats),
        .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
        .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot), .m_axi_arqos(m_axi_arqos),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
        .dout_data(dout_data), .dout_last(dout_last), .dout_valid(dout_valid),
        .dout_ready(dout_ready), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
    } ar_t;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    ar_t   exp_ar[$];
    beat_t exp_beat[$];
    ar_t   sl_q[$];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int ar_cnt = 0;
    int beat_cnt = 0;
    int rlast_cnt = 0;
    int last_cyc = 0;
    logic        r_en = 1'b1;
    logic        bp_mode = 1'b0;
    logic [31:0] err_addr = 32'hFFFF_FFFF;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] beat_data(input logic [31:0] a);
        logic [DW-1:0] d;
        for (int i = 0; i < DW / 32; i++) begin
            d[i*32 +: 32] = a ^ (32'hC0DE_0000 + 32'(i));
        end
        return d;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // monitor: compare AR bursts and stream beats against the scoreboard
    initial forever begin
        ar_t   ea;
        beat_t eb;
        @(negedge clk);
        if (m_axi_arvalid && m_axi_arready) begin
            ar_cnt++;
            chk("ar_pending", exp_ar.size() > 0, 1'b1);
            if (exp_ar.size() > 0) begin
                ea = exp_ar.pop_front();
                chk("araddr", m_axi_araddr, ea.addr);
                chk("arlen", m_axi_arlen, ea.len);
            end
        end
        if (dout_valid && dout_ready) begin
            beat_cnt++;
            chk("beat_pending", exp_beat.size() > 0, 1'b1);
            if (exp_beat.size() > 0) begin
                eb = exp_beat.pop_front();
                chk("dout_data", dout_data, eb.data);
                chk("dout_last", dout_last, eb.last);
            end
            if (dout_last) last_cyc = cyc;
        end
        if (m_axi_rvalid && m_axi_rready && m_axi_rlast) rlast_cnt++;
        if (bp_mode && !done) chk("rready_mirror", m_axi_rready, dout_ready);
    end

    // DDR slave model: in-order INCR bursts, reset together with the master
    initial begin
        logic        s_rst, s_ar, s_r;
        logic [31:0] s_addr, a;
        logic [7:0]  s_len;
        int          sl_i;
        sl_i = 0;
        m_axi_arready = 1'b1;
        m_axi_rvalid = 1'b0;
        m_axi_rdata = '0;
        m_axi_rlast = 1'b0;
        m_axi_rresp = 2'b00;
        m_axi_rid = '0;
        forever begin
            @(negedge clk);
            s_rst  = reset;
            s_ar   = m_axi_arvalid && m_axi_arready;
            s_r    = m_axi_rvalid && m_axi_rready;
            s_addr = m_axi_araddr;
            s_len  = m_axi_arlen;
            @(posedge clk);
            #1;
            if (s_rst) begin
                sl_q.delete();
                sl_i = 0;
            end else begin
                if (s_r && sl_q.size() > 0) begin
                    if (sl_i == int'(sl_q[0].len)) begin
                        void'(sl_q.pop_front());
                        sl_i = 0;
                    end else begin
                        sl_i++;
                    end
                end
                if (s_ar) sl_q.push_back('{addr: s_addr, len: s_len});
            end
            if (!s_rst && r_en && sl_q.size() > 0) begin
                a = sl_q[0].addr + 32'(sl_i * 64);
                m_axi_rvalid = 1'b1;
                m_axi_rdata  = beat_data(a);
                m_axi_rlast  = (sl_i == int'(sl_q[0].len));
                m_axi_rresp  = (a == err_addr) ? 2'b10 : 2'b00;
            end else begin
                m_axi_rvalid = 1'b0;
                m_axi_rlast  = 1'b0;
                m_axi_rresp  = 2'b00;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_beats(input logic [31:0] base, input int n);
        logic [31:0] p;
        p = base & ~32'h3F;
        for (int i = 0; i < n; i++) begin
            exp_beat.push_back('{data: beat_data(p + 32'(i * 64)), last: (i == n - 1)});
        end
    endtask

    task automatic push_split(input logic [31:0] base, input int n);
        logic [31:0] p;
        int rem, k, room;
        p = base & ~32'h3F;
        rem = n;
        while (rem > 0) begin
            room = (4096 - int'(p[11:0])) / 64;
            k = (rem < 16) ? rem : 16;
            if (k > room) k = room;
            exp_ar.push_back('{addr: p, len: 8'(k - 1)});
            p += 32'(k * 64);
            rem -= k;
        end
    endtask

    task automatic send_cmd(input logic [31:0] a, input int n);
        int t;
        t = 0;
        cmd_addr  = a;
        cmd_beats = LW'(n);
        cmd_valid = 1'b1;
        while (!cmd_ready && t < 200) begin
            tick();
            t++;
        end
        chk("cmd_accept", cmd_ready, 1'b1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int t;
        t = 0;
        while (!done && t < 2000) begin
            tick();
            t++;
        end
        chk(tag, done, 1'b1);
    endtask

    // stimulus
    initial begin
        int arc0, b0, rl0, t;
        logic seen;
        reset = 1'b1;
        init_calib_complete = 1'b1;
        cmd_valid = 1'b0;
        cmd_addr = '0;
        cmd_beats = '0;
        dout_ready = 1'b1;
        repeat (3) tick();

        chk("rst_cmd_ready", cmd_ready, 1'b0);
        chk("rst_arvalid", m_axi_arvalid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_dout_valid", dout_valid, 1'b0);
        chk("rst_rready", m_axi_rready, 1'b0);
        chk("rst_araddr", m_axi_araddr, 32'h0);
        chk("rst_arlen", m_axi_arlen, 8'h0);
        reset = 1'b0;
        tick();

        // single short command
        exp_ar.push_back('{addr: 32'h1000, len: 8'd4});
        push_beats(32'h1000, 5);
        b0 = beat_cnt;
        send_cmd(32'h1000, 5);
        chk("t1_busy", busy, 1'b1);
        chk("t1_arvalid", m_axi_arvalid, 1'b1);
        chk("t1_arsize", m_axi_arsize, 3'd6);
        chk("t1_arburst", m_axi_arburst, 2'b01);
        chk("t1_arcache", m_axi_arcache, 4'b0011);
        chk("t1_arid", m_axi_arid, 4'd0);
        wait_done("t1_done");
        chk("t1_done_latency", 32'(cyc), 32'(last_cyc + 1));
        chk("t1_busy_at_done", busy, 1'b0);
        chk("t1_err", err, 1'b0);
        chk("t1_beats", 32'(beat_cnt - b0), 32'd5);
        tick();
        chk("t1_done_pulse", done, 1'b0);

        // 4 KB boundary split
        exp_ar.push_back('{addr: 32'h0FC0, len: 8'd0});
        exp_ar.push_back('{addr: 32'h1000, len: 8'd15});
        exp_ar.push_back('{addr: 32'h1400, len: 8'd15});
        exp_ar.push_back('{addr: 32'h1800, len: 8'd6});
        push_beats(32'h0FC0, 40);
        b0 = beat_cnt;
        send_cmd(32'h0FC0, 40);
        wait_done("t2_done");
        chk("t2_ar_left", 32'(exp_ar.size()), 32'd0);
        chk("t2_beats", 32'(beat_cnt - b0), 32'd40);
        tick();

        // outstanding limit
        r_en = 1'b0;
        push_split(32'h2_0000, 128);
        push_beats(32'h2_0000, 128);
        arc0 = ar_cnt;
        b0 = beat_cnt;
        rl0 = rlast_cnt;
        send_cmd(32'h2_0000, 128);
        repeat (50) tick();
        chk("t3_ar_held", 32'(ar_cnt - arc0), 32'd4);
        chk("t3_arvalid_low", m_axi_arvalid, 1'b0);
        r_en = 1'b1;
        t = 0;
        while (rlast_cnt == rl0 && t < 500) begin
            tick();
            t++;
        end
        chk("t3_first_rlast_ar", 32'(ar_cnt - arc0), 32'd4);
        tick();
        chk("t3_fifth_ar", 32'(ar_cnt - arc0), 32'd5);
        wait_done("t3_done");
        chk("t3_beats", 32'(beat_cnt - b0), 32'd128);
        chk("t3_ar_total", 32'(ar_cnt - arc0), 32'd8);
        tick();

        // backpressure, unaligned low address bits
        push_split(32'h3000, 16);
        push_beats(32'h3000, 16);
        b0 = beat_cnt;
        send_cmd(32'h3015, 16);
        bp_mode = 1'b1;
        t = 0;
        while (!done && t < 500) begin
            dout_ready = ~dout_ready;
            tick();
            t++;
        end
        bp_mode = 1'b0;
        dout_ready = 1'b1;
        chk("t4_done", done, 1'b1);
        chk("t4_beats", 32'(beat_cnt - b0), 32'd16);
        chk("t4_beat_left", 32'(exp_beat.size()), 32'd0);
        tick();

        // error response on beat 3 of 8, then a zero-length command
        err_addr = 32'h4000 + 32'd128;
        push_split(32'h4000, 8);
        push_beats(32'h4000, 8);
        b0 = beat_cnt;
        send_cmd(32'h4000, 8);
        wait_done("t5_done");
        chk("t5_err", err, 1'b1);
        chk("t5_beats", 32'(beat_cnt - b0), 32'd8);
        repeat (3) tick();
        chk("t5_err_sticky", err, 1'b1);
        err_addr = 32'hFFFF_FFFF;
        arc0 = ar_cnt;
        send_cmd(32'h5000, 0);
        chk("t5_zero_done", done, 1'b1);
        chk("t5_zero_err_clr", err, 1'b0);
        tick();
        chk("t5_zero_no_ar", 32'(ar_cnt - arc0), 32'd0);
        chk("t5_zero_idle", busy, 1'b0);

        // calibration gating
        init_calib_complete = 1'b0;
        cmd_addr = 32'h6000;
        cmd_beats = LW'(4);
        cmd_valid = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            tick();
            if (cmd_ready) seen = 1'b1;
        end
        chk("t6_calib_gate", seen, 1'b0);
        chk("t6_calib_busy", busy, 1'b0);
        cmd_valid = 1'b0;
        init_calib_complete = 1'b1;
        tick();

        // reset mid-burst
        push_split(32'h8000, 32);
        push_beats(32'h8000, 32);
        b0 = beat_cnt;
        send_cmd(32'h8000, 32);
        t = 0;
        while ((beat_cnt - b0) < 7 && t < 500) begin
            tick();
            t++;
        end
        chk("t6_reach_beat7", 32'(beat_cnt - b0 >= 7), 32'd1);
        reset = 1'b1;
        tick();
        chk("t6_rst_arvalid", m_axi_arvalid, 1'b0);
        chk("t6_rst_cmd_ready", cmd_ready, 1'b0);
        chk("t6_rst_busy", busy, 1'b0);
        chk("t6_rst_done", done, 1'b0);
        chk("t6_rst_err", err, 1'b0);
        chk("t6_rst_dout_valid", dout_valid, 1'b0);
        chk("t6_rst_rready", m_axi_rready, 1'b0);
        chk("t6_rst_araddr", m_axi_araddr, 32'h0);
        chk("t6_rst_arlen", m_axi_arlen, 8'h0);
        chk("t6_rst_outstanding", u_dut.outstanding, 0);
        reset = 1'b0;
        exp_ar.delete();
        exp_beat.delete();
        tick();

        push_split(32'h9000, 4);
        push_beats(32'h9000, 4);
        b0 = beat_cnt;
        send_cmd(32'h9000, 4);
        wait_done("t7_done");
        chk("t7_beats", 32'(beat_cnt - b0), 32'd4);
        chk("t7_err", err, 1'b0);
        chk("t7_ar_left", 32'(exp_ar.size()), 32'd0);
        chk("t7_beat_left", 32'(exp_beat.size()), 32'd0);
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
